mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port between the instruction-fetch requester and the load/store requester.
- Sits between the fetch stage / LSU and the memory bus.
- Sequences one outstanding transaction at a time through a 3-state FSM.
- Fixed LSU priority, with an anti-starvation limit so fetch always makes forward progress.

Parameters:
- MAX_LS_STREAK, 4: maximum consecutive LSU grants while fetch is waiting. Legal range 1..15.
- TIMEOUT_CYCLES, 64: response watchdog limit. Used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- if_req  in  1  fetch read request
- if_addr  in  32  fetch address
- if_gnt  out  1  fetch request accepted
- if_rvalid  out  1  fetch response valid (1-cycle pulse)
- if_rdata  out  32  fetch instruction word
- if_err  out  1  fetch response error
- ls_req  in  1  LSU request
- ls_we  in  1  LSU write enable
- ls_addr  in  32  LSU address
- ls_wdata  in  32  LSU write data
- ls_wstrb  in  4  LSU byte strobes
- ls_gnt  out  1  LSU request accepted
- ls_rvalid  out  1  LSU response/ack (1-cycle pulse)
- ls_rdata  out  32  LSU load data
- ls_err  out  1  LSU response error
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte strobes
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  32  memory read data
- busy  out  1  transaction in flight

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk. All outputs reset to 0, FSM to IDLE, streak counter to 0.
- Reset mid-transaction: the in-flight transaction is abandoned, mem_req drops immediately, and no response is delivered.
- FSM states: IDLE, REQ, RESP. busy = (state != IDLE).
- IDLE:
  - Arbitration is combinational.
  - Winner = LSU if ls_req && !(if_req && streak == MAX_LS_STREAK); otherwise fetch if if_req.
  - Winner's gnt = 1 in this cycle. The other gnt = 0. Both gnt are 0 outside IDLE.
  - On grant: register owner, addr, we, wdata, wstrb, then go to REQ.
  - Fetch grants force we = 0 and wstrb = 4'hF.
- Streak counter:
  - On an LSU grant with if_req = 1: increment, saturating at MAX_LS_STREAK.
  - On a fetch grant, or an LSU grant with if_req = 0: clear to 0.
- REQ:
  - mem_req = 1, and mem_* are driven from the registered request; all hold stable until mem_gnt.
  - On mem_gnt = 1: mem_req deasserts next cycle; go to RESP.
  - mem_rvalid in REQ is ignored.
- RESP: wait for mem_rvalid. On mem_rvalid:
  - Next cycle, the owner's rvalid pulses for 1 cycle. For reads, owner rdata = captured mem_rdata. For writes, ls_rdata = 0 (ack only).
  - FSM returns to IDLE in that same cycle.
  - Non-owner rvalid/rdata stay 0.
- Latency: grant at cycle T; mem_req at T+1; with mem_gnt at T+1, mem_rvalid earliest at T+2; owner rvalid at T+3; next grant possible at T+3.
  - Throughput is at most 1 transaction per 3 cycles.
- Requester rules:
  - Hold req and its fields until gnt is seen.
  - Deasserting req before gnt is legal and cancels the request.
- mem_rvalid while in IDLE is ignored.
- if_err and ls_err are 0 unless the optional feature fires.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro:
  - A cycle counter runs in RESP. It clears on entering RESP.
  - If the count reaches TIMEOUT_CYCLES without mem_rvalid: the owner's rvalid pulses with err = 1 and rdata = 0, and the FSM returns to IDLE.
  - A late mem_rvalid arriving in IDLE or REQ is ignored.
- Without the macro: no counter exists, RESP waits indefinitely, and if_err and ls_err are tied to 0.

Test Plan:
1. Fetch-only read: if_req = 1, if_addr = 0x100, mem_gnt at T+1, mem_rvalid with rdata 0x00500093 at T+2 -> if_gnt at T, mem_addr = 0x100 with mem_we = 0, if_rvalid with if_rdata = 0x00500093 at T+3.
2. Simultaneous requests: if_req and ls_req both held, LSU issues a read to 0x2000, memory responds with 1-cycle latency -> ls_gnt for 4 consecutive transactions (MAX_LS_STREAK = 4), then if_gnt, then ls_gnt again; streak counter is 0 after the fetch grant.
3. LSU write: ls_we = 1, addr 0x3004, wdata 0xDEADBEEF, wstrb 4'b0011 -> mem_* carry exactly those values; ls_rvalid = 1 with ls_rdata = 0 after mem_rvalid.
4. Memory backpressure: mem_gnt held 0 for 5 cycles -> mem_req and mem_addr stay stable for 6 cycles; no gnt to either requester while busy = 1.
5. Reset mid-operation: resetn = 0 while in RESP -> mem_req = 0, busy = 0, no rvalid pulse; a subsequent mem_rvalid = 1 in IDLE produces no response.
6. With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8: fetch read gets mem_gnt but never mem_rvalid -> 8 cycles after entering RESP, if_rvalid = 1 with if_err = 1 and if_rdata = 0; next if_req is granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 32-bit memory port between instruction fetch and the LSU.
// One transaction is in flight at a time (IDLE -> REQ -> RESP). The LSU has fixed priority,
// but after MAX_LS_STREAK back-to-back LSU grants with fetch waiting, fetch wins once.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN adds a response watchdog. After TIMEOUT_CYCLES
// cycles in RESP without mem_rvalid, the owner gets an error response (err = 1, rdata = 0).
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   if_req/if_addr               fetch read request; if_gnt accepts it (IDLE only)
//   if_rvalid/if_rdata/if_err    fetch response, 1-cycle pulse
//   ls_req/we/addr/wdata/wstrb   LSU request; ls_gnt accepts it (IDLE only)
//   ls_rvalid/ls_rdata/ls_err    LSU response/ack, 1-cycle pulse (rdata = 0 for writes)
//   mem_req/we/addr/wdata/wstrb  memory request, held stable until mem_gnt
//   mem_gnt, mem_rvalid/rdata    memory handshake and response
//   busy                         transaction in flight
module mem_port_arbiter #(
  parameter int unsigned MAX_LS_STREAK  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wstrb,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  if (MAX_LS_STREAK == 0 || MAX_LS_STREAK > 15 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("mem_port_arbiter: illegal parameter value");
  end

  localparam logic [3:0] StreakMax = 4'(MAX_LS_STREAK);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_ls_q, owner_ls_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  streak_q, streak_d;
  logic        rsp_fire;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic        ls_win, if_win;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  // Fetch overrides the LSU only once the LSU has used up its streak while fetch waited.
  // Grants are held off while reset is asserted so every output reads 0 in reset.
  assign ls_win = resetn && ls_req && !(if_req && (streak_q == StreakMax));
  assign if_win = resetn && if_req && !ls_win;

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    streak_d   = streak_q;
    rsp_fire   = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = 32'h0;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      StIdle: begin
        if (ls_win) begin
          ls_gnt     = 1'b1;
          owner_ls_d = 1'b1;
          we_d       = ls_we;
          addr_d     = ls_addr;
          wdata_d    = ls_wdata;
          wstrb_d    = ls_wstrb;
          // Streak only grows while fetch is actually waiting; saturates at the limit.
          if (!if_req) begin
            streak_d = 4'd0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + 4'd1;
          end
          state_d = StReq;
        end else if (if_win) begin
          if_gnt     = 1'b1;
          owner_ls_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = if_addr;
          wdata_d    = 32'h0;
          wstrb_d    = 4'hF;
          streak_d   = 4'd0;
          state_d    = StReq;
        end
      end
      StReq: begin
        // A stray mem_rvalid here belongs to nothing we issued and is dropped.
        if (mem_gnt) begin
          state_d = StResp;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      StResp: begin
        if (mem_rvalid) begin
          rsp_fire = 1'b1;
          rsp_data = we_q ? 32'h0 : mem_rdata;
          state_d  = StIdle;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (tmo_q == TmoLast) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      owner_ls_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      streak_q   <= 4'd0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'h0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= 32'h0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      streak_q   <= streak_d;
      if_rvalid  <= rsp_fire && !owner_ls_q;
      if_rdata   <= (rsp_fire && !owner_ls_q) ? rsp_data : 32'h0;
      ls_rvalid  <= rsp_fire && owner_ls_q;
      ls_rdata   <= (rsp_fire && owner_ls_q) ? rsp_data : 32'h0;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_q  <= '0;
      if_err <= 1'b0;
      ls_err <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      if_err <= rsp_fire && rsp_err && !owner_ls_q;
      ls_err <= rsp_fire && rsp_err && owner_ls_q;
    end
  end
`else
  assign if_err = 1'b0;
  assign ls_err = 1'b0;
  logic unused_rsp_err;
  assign unused_rsp_err = rsp_err;
`endif

  assign mem_req   = (state_q == StReq);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset checks, directed corner sequences,
// a cycle table for the LSU streak / fetch anti-starvation pattern, and a randomized run
// against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned MaxStreak = 4;
  localparam int unsigned Tmo       = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wstrb;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_LS_STREAK (MaxStreak),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_wstrb  (ls_wstrb),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .ls_err    (ls_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  typedef struct {
    logic        if_req, ls_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        e_if_gnt, e_ls_gnt, e_mem_req, e_busy, e_if_rv, e_ls_rv;
    logic [31:0] e_addr, e_rdata;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_wstrb = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic reset_dut(input bit do_check);
    @(negedge clk);
    idle_inputs();
    resetn = 0;
    if_req = 1; ls_req = 1;
    @(negedge clk);
    #1;
    if (do_check) begin
      chk("rst_if_gnt", if_gnt, 0);     chk("rst_ls_gnt", ls_gnt, 0);
      chk("rst_mem_req", mem_req, 0);   chk("rst_busy", busy, 0);
      chk("rst_if_rvalid", if_rvalid, 0); chk("rst_ls_rvalid", ls_rvalid, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wstrb", mem_wstrb, 0);
      chk("rst_if_err", if_err, 0);     chk("rst_ls_err", ls_err, 0);
    end
    @(negedge clk);
    idle_inputs();
    resetn = 1;
  endtask

  // Reference model state (transaction level)
  int unsigned m_streak;
  bit          m_open, m_acc, m_ls, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  bit          r_v, r_ls, r_err;
  logic [31:0] r_data;
  bit          e_ifg, e_lsg, last_ifg, last_lsg;
`ifdef MEM_ARB_TIMEOUT_EN
  int unsigned m_wait;
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 0;
    idle_inputs();
    reset_dut(1);

    // Fetch-only read
    if_req = 1; if_addr = 32'h100;
    #1 chk("t1_if_gnt", if_gnt, 1); chk("t1_ls_gnt", ls_gnt, 0); chk("t1_busy0", busy, 0);
    @(negedge clk); if_req = 0; mem_gnt = 1;
    #1 chk("t1_mem_req", mem_req, 1); chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0); chk("t1_mem_wstrb", mem_wstrb, 4'hF); chk("t1_busy1", busy, 1);
    @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    #1 chk("t1_mem_req_drop", mem_req, 0); chk("t1_early_rv", if_rvalid, 0);
    @(negedge clk); mem_rvalid = 0; mem_rdata = 0;
    #1 chk("t1_if_rvalid", if_rvalid, 1); chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    chk("t1_ls_rvalid", ls_rvalid, 0); chk("t1_busy2", busy, 0);
    @(negedge clk);
    #1 chk("t1_pulse_end", if_rvalid, 0);
    @(negedge clk);

    // LSU write
    ls_req = 1; ls_we = 1; ls_addr = 32'h3004; ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'b0011;
    #1 chk("t3_ls_gnt", ls_gnt, 1);
    @(negedge clk); ls_req = 0; ls_we = 0; ls_wdata = 0; ls_wstrb = 0; mem_gnt = 1;
    #1 chk("t3_mem_we", mem_we, 1); chk("t3_mem_addr", mem_addr, 32'h3004);
    chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF); chk("t3_mem_wstrb", mem_wstrb, 4'b0011);
    @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk); mem_rvalid = 0;
    #1 chk("t3_ls_rvalid", ls_rvalid, 1); chk("t3_ls_rdata", ls_rdata, 0);
    chk("t3_if_rvalid", if_rvalid, 0);
    @(negedge clk);

    // Memory backpressure: no mem_gnt for 5 cycles
    ls_req = 1; ls_addr = 32'h4440;
    #1 chk("t4_ls_gnt", ls_gnt, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mem_gnt = (k == 5); if_req = (k < 5); ls_req = (k < 5);
      #1 chk("t4_mem_req", mem_req, 1); chk("t4_mem_addr", mem_addr, 32'h4440);
      chk("t4_if_gnt", if_gnt, 0); chk("t4_ls_gnt_busy", ls_gnt, 0); chk("t4_busy", busy, 1);
    end
    @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55;
    #1 chk("t4_mem_req_drop", mem_req, 0);
    @(negedge clk); mem_rvalid = 0;
    #1 chk("t4_ls_rvalid", ls_rvalid, 1); chk("t4_ls_rdata", ls_rdata, 32'h55);
    @(negedge clk);

    // Streak table: both requesters held, 1-cycle memory
    begin
      vec_t v;
      bit   prev_f;
      prev_f = 0;
      for (int t = 0; t < 10; t++) begin
        bit f;
        f = (t == 4) || (t == 9);
        v = '{default: '0};
        v.if_req = 1; v.ls_req = 1;
        v.e_if_gnt = f; v.e_ls_gnt = !f;
        v.e_if_rv = (t > 0) && prev_f; v.e_ls_rv = (t > 0) && !prev_f;
        v.e_rdata = 32'hA000_0000 + 32'(t) - 32'd1;
        vecs.push_back(v);
        v = '{default: '0};
        v.if_req = 1; v.ls_req = 1; v.mem_gnt = 1;
        v.e_mem_req = 1; v.e_busy = 1; v.e_addr = f ? 32'h100 : 32'h2000;
        vecs.push_back(v);
        v = '{default: '0};
        v.if_req = 1; v.ls_req = 1; v.mem_rvalid = 1; v.mem_rdata = 32'hA000_0000 + 32'(t);
        v.e_busy = 1;
        vecs.push_back(v);
        prev_f = f;
      end
      v = '{default: '0};
      v.e_if_rv = 1; v.e_rdata = 32'hA000_0009;
      vecs.push_back(v);
    end
    reset_dut(0);
    if_addr = 32'h100; ls_addr = 32'h2000; ls_we = 0; ls_wstrb = 4'hF;
    for (int i = 0; i < vecs.size(); i++) begin
      if_req = vecs[i].if_req; ls_req = vecs[i].ls_req; mem_gnt = vecs[i].mem_gnt;
      mem_rvalid = vecs[i].mem_rvalid; mem_rdata = vecs[i].mem_rdata;
      #1;
      chk($sformatf("tbl%0d_if_gnt", i), if_gnt, vecs[i].e_if_gnt);
      chk($sformatf("tbl%0d_ls_gnt", i), ls_gnt, vecs[i].e_ls_gnt);
      chk($sformatf("tbl%0d_mem_req", i), mem_req, vecs[i].e_mem_req);
      chk($sformatf("tbl%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("tbl%0d_if_rv", i), if_rvalid, vecs[i].e_if_rv);
      chk($sformatf("tbl%0d_ls_rv", i), ls_rvalid, vecs[i].e_ls_rv);
      if (vecs[i].e_mem_req) chk($sformatf("tbl%0d_addr", i), mem_addr, vecs[i].e_addr);
      if (vecs[i].e_if_rv) chk($sformatf("tbl%0d_if_rdata", i), if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_ls_rv) chk($sformatf("tbl%0d_ls_rdata", i), ls_rdata, vecs[i].e_rdata);
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);

    // Reset while in RESP
    if_req = 1; if_addr = 32'h200;
    #1 chk("t5_if_gnt", if_gnt, 1);
    @(negedge clk); if_req = 0; mem_gnt = 1;
    #1 chk("t5_mem_req", mem_req, 1);
    @(negedge clk); mem_gnt = 0;
    #1 chk("t5_busy_resp", busy, 1);
    resetn = 0;
    #1 chk("t5_rst_mem_req", mem_req, 0); chk("t5_rst_busy", busy, 0);
    chk("t5_rst_if_rv", if_rvalid, 0);
    @(negedge clk);
    @(negedge clk); resetn = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0;
    #1 chk("t5_idle_busy", busy, 0);
    @(negedge clk); mem_rvalid = 0;
    #1 chk("t5_no_if_rv", if_rvalid, 0); chk("t5_no_ls_rv", ls_rvalid, 0);
    chk("t5_still_idle", busy, 0);
    @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    // Response watchdog
    if_req = 1; if_addr = 32'h300;
    #1 chk("t6_if_gnt", if_gnt, 1);
    @(negedge clk); if_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hCAFE;
    #1 chk("t6_mem_req", mem_req, 1);
    @(negedge clk); mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    for (int k = 0; k < int'(Tmo); k++) begin
      #1 chk("t6_wait_rv", if_rvalid, 0); chk("t6_wait_busy", busy, 1);
      @(negedge clk);
    end
    if_req = 1; if_addr = 32'h304;
    #1 chk("t6_tmo_rv", if_rvalid, 1); chk("t6_tmo_err", if_err, 1);
    chk("t6_tmo_rdata", if_rdata, 0); chk("t6_tmo_ls_rv", ls_rvalid, 0);
    chk("t6_regrant", if_gnt, 1);
    @(negedge clk); if_req = 0; mem_gnt = 1;
    #1 chk("t6_addr2", mem_addr, 32'h304);
    @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    @(negedge clk); mem_rvalid = 0;
    #1 chk("t6_rv2", if_rvalid, 1); chk("t6_err2", if_err, 0); chk("t6_rdata2", if_rdata, 32'h77);
    @(negedge clk);
`endif

    // Randomized run against the reference model
    reset_dut(0);
    m_streak = 0; m_open = 0; m_acc = 0; r_v = 0; r_ls = 0; r_err = 0; r_data = 0;
    last_ifg = 0; last_lsg = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!(if_req && !last_ifg && $urandom_range(0, 15) != 0)) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
      end
      if (!(ls_req && !last_lsg && $urandom_range(0, 15) != 0)) begin
        ls_req = 1'($urandom_range(0, 1)); ls_we = 1'($urandom_range(0, 1));
        ls_addr = $urandom; ls_wdata = $urandom; ls_wstrb = 4'($urandom);
      end
      mem_gnt = ($urandom_range(0, 2) != 0);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #1;
      e_ifg = 0; e_lsg = 0;
      if (!m_open) begin
        if (ls_req && !(if_req && m_streak == MaxStreak)) e_lsg = 1;
        else if (if_req) e_ifg = 1;
      end
      chk("rnd_if_gnt", if_gnt, e_ifg);
      chk("rnd_ls_gnt", ls_gnt, e_lsg);
      chk("rnd_busy", busy, m_open);
      chk("rnd_mem_req", mem_req, m_open && !m_acc);
      chk("rnd_if_rv", if_rvalid, r_v && !r_ls);
      chk("rnd_ls_rv", ls_rvalid, r_v && r_ls);
      if (r_v) begin
        chk("rnd_if_rdata", if_rdata, r_ls ? 32'h0 : r_data);
        chk("rnd_ls_rdata", ls_rdata, r_ls ? r_data : 32'h0);
        chk("rnd_if_err", if_err, !r_ls && r_err);
        chk("rnd_ls_err", ls_err, r_ls && r_err);
      end
      if (m_open && !m_acc) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_we", mem_we, m_we);
        chk("rnd_mem_wstrb", mem_wstrb, m_wstrb);
        if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      r_v = 0; r_err = 0; r_data = 0;
      if (m_open) begin
        if (!m_acc) begin
          if (mem_gnt) begin
            m_acc = 1;
`ifdef MEM_ARB_TIMEOUT_EN
            m_wait = 0;
`endif
          end
        end else if (mem_rvalid) begin
          r_v = 1; r_ls = m_ls; r_data = m_we ? 32'h0 : mem_rdata; m_open = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (m_wait == Tmo - 1) begin
          r_v = 1; r_ls = m_ls; r_err = 1; m_open = 0;
        end else begin
          m_wait++;
`endif
        end
      end else if (e_lsg) begin
        m_open = 1; m_acc = 0; m_ls = 1; m_we = ls_we;
        m_addr = ls_addr; m_wdata = ls_wdata; m_wstrb = ls_wstrb;
        m_streak = !if_req ? 0 : (m_streak < MaxStreak ? m_streak + 1 : MaxStreak);
      end else if (e_ifg) begin
        m_open = 1; m_acc = 0; m_ls = 0; m_we = 0;
        m_addr = if_addr; m_wdata = 0; m_wstrb = 4'hF;
        m_streak = 0;
      end
      last_ifg = e_ifg; last_lsg = e_lsg;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
